// File: rtl/vga_overlay_pkg.sv
// Shared types and glyph constants for the VGA digit overlay.
package vga_overlay_pkg;

  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned GLYPH_H    = 12;
  localparam int unsigned DIGIT_BITS = 4;

  typedef logic [GLYPH_W-1:0]    glyph_row_t;
  typedef logic [DIGIT_BITS-1:0] bcd_digit_t;

  // Video control bundle carried alongside the pixel pipeline.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } vid_ctl_t;

endpackage

// File: rtl/digit_glyph_rom.sv
// 8x12 decimal digit font ROM with a registered output row.
module digit_glyph_rom
  import vga_overlay_pkg::*;
(
  input  logic       clk,
  input  bcd_digit_t digit,
  input  logic [3:0] row,
  output glyph_row_t row_bits
);

  localparam int unsigned FONT_W = GLYPH_W * GLYPH_H;

  logic [FONT_W-1:0] glyph_c;
  logic [FONT_W-1:0] shifted_c;
  glyph_row_t        row_c;

  // Row 0 occupies the top byte of each glyph word.
  always_comb begin
    glyph_c = '0;
    case (digit)
      4'd0: glyph_c = 96'h3C66_666E_7666_6666_6666_3C00;
      4'd1: glyph_c = 96'h1838_7818_1818_1818_1818_7E00;
      4'd2: glyph_c = 96'h3C66_0606_0C18_3060_6066_7E00;
      4'd3: glyph_c = 96'h3C66_0606_1C06_0606_0666_3C00;
      4'd4: glyph_c = 96'h0C1C_3C6C_CCCC_FE0C_0C0C_1E00;
      4'd5: glyph_c = 96'h7E60_6060_7C06_0606_0666_3C00;
      4'd6: glyph_c = 96'h1C30_6060_7C66_6666_6666_3C00;
      4'd7: glyph_c = 96'h7E66_0606_0C18_1818_1818_1800;
      4'd8: glyph_c = 96'h7E66_6666_3C66_6666_6666_7E00;
      4'd9: glyph_c = 96'h3C66_6666_663E_0606_060C_3800;
      default: glyph_c = '0;
    endcase
  end

  always_comb begin
    shifted_c = glyph_c << {row, 3'b000};
    row_c     = '0;
    if (row < 4'(GLYPH_H)) row_c = shifted_c[FONT_W-1 -: GLYPH_W];
  end

  always_ff @(posedge clk) begin
    row_bits <= row_c;
  end

endmodule

// File: rtl/vga_digit_overlay.sv
// N-digit BCD text overlay: 3-stage pixel pipeline with frame-synchronous value swap.
module vga_digit_overlay
  import vga_overlay_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned X0         = 16,
  parameter int unsigned Y0         = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [COORD_W-1:0]              pixel_x,
  input  logic [COORD_W-1:0]              pixel_y,
  input  logic                            de_in,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start,
  input  logic [DIGIT_BITS*NUM_DIGITS-1:0] value_bcd,
  input  logic                            value_valid,
  input  logic                            lz_blank,
  output logic                            pixel_on,
  output logic                            de_out,
  output logic                            hsync_out,
  output logic                            vsync_out
);

  localparam int unsigned VAL_W = DIGIT_BITS * NUM_DIGITS;
  localparam int unsigned EXT_W = COORD_W + 1;
  localparam int unsigned CW    = GLYPH_W << SCALE_LOG2;
  localparam int unsigned CH    = GLYPH_H << SCALE_LOG2;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned COL_W = 3;
  localparam int unsigned ROW_W = 4;

  logic [VAL_W-1:0]      pending;
  logic [VAL_W-1:0]      active;
  logic [NUM_DIGITS-1:0] blank_mask;

  logic [VAL_W-1:0]      load_c;
  logic [NUM_DIGITS-1:0] mask_c;
  logic                  zero_run;

  // Value seen by the swap: value_valid in the same cycle bypasses pending.
  always_comb begin
    load_c   = value_valid ? value_bcd : pending;
    mask_c   = '0;
    zero_run = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      zero_run = zero_run & (load_c[VAL_W-1-DIGIT_BITS*i -: DIGIT_BITS] == '0);
      if (i < int'(NUM_DIGITS) - 1) mask_c[i] = lz_blank & zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      active     <= '0;
      blank_mask <= '0;
    end else begin
      if (value_valid) pending <= value_bcd;
      if (frame_start) begin
        active     <= load_c;
        blank_mask <= mask_c;
      end
    end
  end

  logic [EXT_W-1:0] x_ext_c;
  logic [EXT_W-1:0] y_ext_c;
  logic [EXT_W-1:0] dx_c;
  logic [EXT_W-1:0] dy_c;
  logic             in_box_c;

  // Extra MSB keeps box bounds from wrapping near the right/bottom edge.
  always_comb begin
    x_ext_c  = {1'b0, pixel_x};
    y_ext_c  = {1'b0, pixel_y};
    dx_c     = x_ext_c - EXT_W'(X0);
    dy_c     = y_ext_c - EXT_W'(Y0);
    in_box_c = (x_ext_c >= EXT_W'(X0)) && (x_ext_c < EXT_W'(X0 + NUM_DIGITS * CW)) &&
               (y_ext_c >= EXT_W'(Y0)) && (y_ext_c < EXT_W'(Y0 + CH));
  end

  logic             s1_in_box;
  logic [IDX_W-1:0] s1_idx;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  vid_ctl_t         s1_ctl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_in_box <= 1'b0;
      s1_idx    <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_ctl    <= '0;
    end else begin
      s1_in_box <= in_box_c;
      s1_idx    <= IDX_W'(dx_c >> (3 + SCALE_LOG2));
      s1_col    <= COL_W'(dx_c >> SCALE_LOG2);
      s1_row    <= ROW_W'(dy_c >> SCALE_LOG2);
      s1_ctl    <= '{de: de_in, hsync: hsync_in, vsync: vsync_in};
    end
  end

  bcd_digit_t nib_c;
  logic       blank_c;

  always_comb begin
    nib_c   = '0;
    blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (s1_idx == IDX_W'(i)) begin
        nib_c   = active[VAL_W-1-DIGIT_BITS*i -: DIGIT_BITS];
        blank_c = blank_mask[i];
      end
    end
  end

  glyph_row_t       rom_row;
  logic             s2_in_box;
  logic             s2_blank;
  logic [COL_W-1:0] s2_col;
  vid_ctl_t         s2_ctl;

  digit_glyph_rom u_rom (
    .clk      (clk),
    .digit    (nib_c),
    .row      (s1_row),
    .row_bits (rom_row)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_in_box <= 1'b0;
      s2_blank  <= 1'b0;
      s2_col    <= '0;
      s2_ctl    <= '0;
    end else begin
      s2_in_box <= s1_in_box;
      s2_blank  <= blank_c;
      s2_col    <= s1_col;
      s2_ctl    <= s1_ctl;
    end
  end

  // Bit 7 of the glyph row is the leftmost pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_on  <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pixel_on  <= s2_ctl.de & s2_in_box & ~s2_blank & rom_row[3'd7 - s2_col];
      de_out    <= s2_ctl.de;
      hsync_out <= s2_ctl.hsync;
      vsync_out <= s2_ctl.vsync;
    end
  end

endmodule
